// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch FIFO that splits the head word into an opcode and an operand field.
// Define IPQ_BYPASS_EN to let a word entering an empty queue reach the outputs in the same cycle.
module inst_prefetch_queue #(
  parameter int INST_W = 16,
  parameter int OP_W   = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OP_W-1:0]          out_op,
  output logic [INST_W-OP_W-1:0]   out_field,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] head_word;

  assign in_ready = !reset && (count_q < FULL_C);

`ifdef IPQ_BYPASS_EN
  assign bypass    = (count_q == '0) && in_valid && !reset && !flush;
  assign head_word = bypass ? in_inst : mem_q[head_q];
`else
  assign bypass    = 1'b0;
  assign head_word = mem_q[head_q];
`endif

  assign out_valid = (count_q != '0) || bypass;
  assign out_op    = out_valid ? head_word[OP_W-1:0] : '0;
  assign out_field = out_valid ? head_word[INST_W-1:OP_W] : '0;
  assign count     = count_q;

  // A bypassed word that the consumer takes immediately never occupies a slot.
  assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
  assign pop  = (count_q != '0) && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; only count decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_inst;
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Scoreboard bench for inst_prefetch_queue (INST_W=16, OP_W=5, DEPTH=4); honours IPQ_BYPASS_EN.
module tb_inst_prefetch_queue;

`ifdef IPQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  out_op;
  logic [10:0] out_field;
  logic        out_ready;
  logic [2:0]  count;

  typedef struct {
    string       name;
    logic [2:0]  cnt;
    logic        inRdy;
    logic        outVld;
    logic        chkData;
    logic [4:0]  op;
    logic [10:0] field;
    logic        sbEmpty;
  } statusT;

  logic [15:0] dataQ [$];
  statusT      statusQ [$];
  statusT      s;
  logic [15:0] expWord;
  int          checks = 0;
  int          errors = 0;

  inst_prefetch_queue #(.INST_W(16), .OP_W(5), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_op    (out_op),
    .out_field (out_field),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares queued status expectations and every handshake against the scoreboard.
  always @(negedge clk) begin
    if (statusQ.size() > 0) begin
      s = statusQ.pop_front();
      checks++;
      if (count !== s.cnt || in_ready !== s.inRdy || out_valid !== s.outVld ||
          (s.chkData && (out_op !== s.op || out_field !== s.field))) begin
        errors++;
        $display("[TB] FAIL %s: got count=%0d in_ready=%0b out_valid=%0b op=%h field=%h, want count=%0d in_ready=%0b out_valid=%0b op=%h field=%h",
                 s.name, count, in_ready, out_valid, out_op, out_field,
                 s.cnt, s.inRdy, s.outVld, s.op, s.field);
      end
      if (s.sbEmpty) begin
        checks++;
        if (dataQ.size() != 0) begin
          errors++;
          $display("[TB] FAIL %s: %0d expected words never output, want 0", s.name, dataQ.size());
        end
      end
    end
    if (out_valid && out_ready && !reset && !flush) begin
      checks++;
      if (dataQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop: unexpected word op=%h field=%h, want no output", out_op, out_field);
      end else begin
        expWord = dataQ.pop_front();
        if (out_op !== expWord[4:0] || out_field !== expWord[15:5]) begin
          errors++;
          $display("[TB] FAIL pop: got op=%h field=%h, want op=%h field=%h (word %h)",
                   out_op, out_field, expWord[4:0], expWord[15:5], expWord);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                               input logic [15:0] inst, input logic ordy, input logic acc);
    @(posedge clk);
    #1;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_inst   = inst;
    out_ready = ordy;
    if (rst || fl) dataQ.delete();
    if (acc) dataQ.push_back(inst);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] cnt, input logic inRdy,
                             input logic outVld, input logic chkData, input logic [4:0] op,
                             input logic [10:0] field, input logic sbEmpty);
    statusT t;
    t.name    = name;
    t.cnt     = cnt;
    t.inRdy   = inRdy;
    t.outVld  = outVld;
    t.chkData = chkData;
    t.op      = op;
    t.field   = field;
    t.sbEmpty = sbEmpty;
    statusQ.push_back(t);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b0;

    // Reset held two cycles with a word offered
    applyStimulus(1, 0, 1, 16'h1234, 0, 0); checkOutput("reset1", 0, 0, 0, 1, 5'h00, 11'h000, 0);
    applyStimulus(1, 0, 1, 16'h1234, 0, 0); checkOutput("reset2", 0, 0, 0, 1, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0); checkOutput("resetRelease", 0, 1, 0, 1, 5'h00, 11'h000, 0);

    // Opcode/field split
    applyStimulus(0, 0, 1, 16'hA5C3, 0, 1); checkOutput("splitPush", 0, 1, BYP, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("splitHead", 1, 1, 1, 1, 5'h03, 11'h52E, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0); checkOutput("splitEmpty", 0, 1, 0, 1, 5'h00, 11'h000, 0);

    // Fill past full, then wrap
    applyStimulus(0, 0, 1, 16'h0001, 0, 1); checkOutput("fill1", 0, 1, BYP, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0002, 0, 1); checkOutput("fill2", 1, 1, 1, 1, 5'h01, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0003, 0, 1); checkOutput("fill3", 2, 1, 1, 1, 5'h01, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0004, 0, 1); checkOutput("fill4", 3, 1, 1, 1, 5'h01, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0005, 0, 0); checkOutput("fullRefuse", 4, 0, 1, 1, 5'h01, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("popA", 4, 0, 1, 1, 5'h01, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("popB", 3, 1, 1, 1, 5'h02, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0006, 0, 1); checkOutput("wrapPush6", 2, 1, 1, 1, 5'h03, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0007, 0, 1); checkOutput("wrapPush7", 3, 1, 1, 1, 5'h03, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0); checkOutput("wrapFull", 4, 0, 1, 1, 5'h03, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("drain1", 4, 0, 1, 1, 5'h03, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("drain2", 3, 1, 1, 1, 5'h04, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("drain3", 2, 1, 1, 1, 5'h06, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("drain4", 1, 1, 1, 1, 5'h07, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("drainEmpty", 0, 1, 0, 1, 5'h00, 11'h000, 0);

    // Simultaneous push and pop at count=2
    applyStimulus(0, 0, 1, 16'h1111, 0, 1); checkOutput("simPush1", 0, 1, BYP, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h2222, 0, 1); checkOutput("simPush2", 1, 1, 1, 1, 5'h11, 11'h088, 0);
    applyStimulus(0, 0, 1, 16'h3333, 1, 1); checkOutput("simBoth", 2, 1, 1, 1, 5'h11, 11'h088, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0); checkOutput("simAfter", 2, 1, 1, 1, 5'h02, 11'h111, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("simDrain1", 2, 1, 1, 1, 5'h02, 11'h111, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("simDrain2", 1, 1, 1, 1, 5'h13, 11'h199, 0);

    // Flush at count=3 with push and pop requested
    applyStimulus(0, 0, 1, 16'h0A0A, 0, 1); checkOutput("flPush1", 0, 1, BYP, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0B0B, 0, 1); checkOutput("flPush2", 1, 1, 1, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h0C0C, 0, 1); checkOutput("flPush3", 2, 1, 1, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 1, 1, 16'h0D0D, 1, 0); checkOutput("flushCycle", 3, 1, 1, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("flushAfter", 0, 1, 0, 1, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("flushIdle", 0, 1, 0, 1, 5'h00, 11'h000, 0);

    // Bypass (or its absence) into an empty queue with the consumer ready
    applyStimulus(0, 0, 1, 16'hFFE0, 1, 1);
    checkOutput("bypassSame", 0, 1, BYP, 1, 5'h00, BYP ? 11'h7FF : 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0);
    checkOutput("bypassNext", BYP ? 3'd0 : 3'd1, 1, !BYP, 1, 5'h00, BYP ? 11'h000 : 11'h7FF, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0); checkOutput("bypassIdle", 0, 1, 0, 1, 5'h00, 11'h000, 0);

    // Reset mid-stream discards queued words
    applyStimulus(0, 0, 1, 16'h5555, 0, 1); checkOutput("rsPush1", 0, 1, BYP, 0, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 1, 16'h6666, 0, 1); checkOutput("rsPush2", 1, 1, 1, 1, 5'h15, 11'h2AA, 0);
    applyStimulus(1, 0, 1, 16'h7777, 1, 0); checkOutput("rsAssert", 2, 0, 1, 1, 5'h15, 11'h2AA, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("rsAfter", 0, 1, 0, 1, 5'h00, 11'h000, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0); checkOutput("rsIdle", 0, 1, 0, 1, 5'h00, 11'h000, 1);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
